// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding constants, mnemonic codes and loader FSM states.
package legv8_pkg;

    typedef enum logic [3:0] {
        M_LDUR = 4'd0,
        M_STUR = 4'd1,
        M_CBZ  = 4'd2,
        M_ADD  = 4'd3,
        M_SUB  = 4'd4,
        M_AND  = 4'd5,
        M_ORR  = 4'd6,
        M_B    = 4'd7,
        M_BR   = 4'd8
    } mnem_t;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_BR   = 11'b11010110000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [31:0] NOP_WORD = 32'h8B1F03FF;

    localparam int D_IMM_MIN  = -256;
    localparam int D_IMM_MAX  = 255;
    localparam int CB_IMM_MIN = -(1 << 18);
    localparam int CB_IMM_MAX = (1 << 18) - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_DONE
    } state_t;

endpackage

// File: rtl/instenc_loader_instenc.sv
// Combinational LEGv8 encoder: symbolic fields to a 32-bit word plus reject flags.
module instenc
    import legv8_pkg::*;
(
    input  logic [3:0]  mnem_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rn_i,
    input  logic [4:0]  rm_i,
    input  logic [25:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o,
    output logic        range_err_o
);

    logic signed [31:0] simm;
    assign simm = {{6{imm_i[25]}}, imm_i};

    always_comb begin
        word_o      = '0;
        illegal_o   = 1'b0;
        range_err_o = 1'b0;
        case (mnem_i)
            M_LDUR: begin
                word_o      = {OP_LDUR, imm_i[8:0], 2'b00, rn_i, rd_i};
                range_err_o = (simm < D_IMM_MIN) || (simm > D_IMM_MAX);
            end
            M_STUR: begin
                word_o      = {OP_STUR, imm_i[8:0], 2'b00, rn_i, rd_i};
                range_err_o = (simm < D_IMM_MIN) || (simm > D_IMM_MAX);
            end
            M_CBZ: begin
                word_o      = {OP_CBZ, imm_i[18:0], rd_i};
                range_err_o = (simm < CB_IMM_MIN) || (simm > CB_IMM_MAX);
            end
            M_ADD:   word_o = {OP_ADD, rm_i, 6'b0, rn_i, rd_i};
            M_SUB:   word_o = {OP_SUB, rm_i, 6'b0, rn_i, rd_i};
            M_AND:   word_o = {OP_AND, rm_i, 6'b0, rn_i, rd_i};
            M_ORR:   word_o = {OP_ORR, rm_i, 6'b0, rn_i, rd_i};
            M_B:     word_o = {OP_B, imm_i};
            M_BR:    word_o = {OP_BR, 5'b0, 6'b0, rn_i, 5'b0};
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instenc_loader.sv
// Streams symbolic instructions into imem as LEGv8 words, then pads the tail with NOPs.
module instenc_loader
    import legv8_pkg::*;
#(
    parameter int N_WORDS = 64,
    parameter int AW      = $clog2(N_WORDS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_mnem,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rn,
    input  logic [4:0]    in_rm,
    input  logic [25:0]   in_imm,
    input  logic          in_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err_illegal,
    output logic          err_range,
    output logic [AW:0]   count
);

    localparam logic [AW:0] NW = (AW+1)'(N_WORDS);

    state_t        state_q, state_d;
    logic [AW:0]   ptr_q, ptr_d, nptr;
    logic [AW:0]   count_q, count_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          ill_q, ill_d, rng_q, rng_d;
    logic          busy_q, done_q;
    logic [31:0]   enc_word;
    logic          enc_ill, enc_rng, hs;

    instenc u_enc (
        .mnem_i      (in_mnem),
        .rd_i        (in_rd),
        .rn_i        (in_rn),
        .rm_i        (in_rm),
        .imm_i       (in_imm),
        .word_o      (enc_word),
        .illegal_o   (enc_ill),
        .range_err_o (enc_rng)
    );

    assign in_ready = (state_q == S_LOAD) && !start && (ptr_q < NW);
    assign hs       = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ill_d   = ill_q;
        rng_d   = rng_q;
        nptr    = ptr_q;
        // start overrides everything, including an in-progress pad sweep
        if (start) begin
            state_d = S_LOAD;
            ptr_d   = '0;
            count_d = '0;
            ill_d   = 1'b0;
            rng_d   = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (hs) begin
                        if (enc_ill) begin
                            ill_d = 1'b1;
                        end else if (enc_rng) begin
                            rng_d = 1'b1;
                        end else begin
                            we_d    = 1'b1;
                            addr_d  = ptr_q[AW-1:0];
                            wdata_d = enc_word;
                            nptr    = ptr_q + 1'b1;
                            count_d = nptr;
                        end
                        ptr_d = nptr;
                        if (in_last)
                            state_d = (nptr < NW) ? S_FILL : S_DONE;
                        else if (nptr == NW)
                            state_d = S_DONE;
                    end else if (ptr_q == NW) begin
                        state_d = S_DONE;
                    end
                end
                S_FILL: begin
                    // stay in FILL while the last pad write is presented so done lags it by one
                    if (ptr_q < NW) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q[AW-1:0];
                        wdata_d = NOP_WORD;
                        ptr_d   = ptr_q + 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ill_q   <= 1'b0;
            rng_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ill_q   <= ill_d;
            rng_q   <= rng_d;
            busy_q  <= (state_d == S_LOAD) || (state_d == S_FILL);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_illegal = ill_q;
    assign err_range   = rng_q;
    assign count       = count_q;

endmodule

// File: doc/instenc_loader.md
# instenc_loader

Sequential LEGv8 instruction encoder and instruction-memory loader: the encode-side counterpart of the main control decoder. It accepts symbolic instructions (mnemonic plus register and immediate fields) over a valid/ready stream. It encodes each one into a 32-bit LEGv8 word and writes it into instruction memory at consecutive addresses. After the last instruction it pads the rest of memory with NOPs. It sits between the testbench/boot host and the imem write port, ahead of the single-cycle core.

## Interface
- `N_WORDS`, 64: imem depth in words; must be ≥2.
- `AW`, `$clog2(N_WORDS)`: imem address width.

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  begin/restart a load (pulse).
- `in_valid`  in  1  instruction fields valid.
- `in_ready`  out  1  block accepts fields this cycle.
- `in_mnem`  in  4  mnemonic code (see Operation).
- `in_rd`  in  5  Rd/Rt.
- `in_rn`  in  5  Rn (BR: target register).
- `in_rm`  in  5  Rm.
- `in_imm`  in  26  signed immediate (DT_address / CB offset / B offset).
- `in_last`  in  1  final instruction of the program.
- `imem_we`  out  1  imem write strobe.
- `imem_addr`  out  AW  word address.
- `imem_wdata`  out  32  encoded instruction.
- `busy`  out  1  state is LOAD or FILL.
- `done`  out  1  state is DONE.
- `err_illegal`  out  1  sticky: unknown mnemonic rejected.
- `err_range`  out  1  sticky: immediate out of range, rejected.
- `count`  out  AW+1  program words written, excluding padding.

## Operation
- Mnemonic codes: 0 LDUR, 1 STUR, 2 CBZ, 3 ADD, 4 SUB, 5 AND, 6 ORR, 7 B, 8 BR. Codes 9–15 are illegal.
- R-format ADD/SUB/AND/ORR: `{op11, rm, 6'b0, rn, rd}`. Opcodes: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
- D-format: `{op11, imm[8:0], 2'b00, rn, rd}`. Opcodes: LDUR 11111000010, STUR 11111000000. The immediate must lie in −256..255.
- CBZ: `{8'b10110100, imm[18:0], rd}`. The immediate must lie in −2^18..2^18−1.
- B: `{6'b000101, imm[25:0]}`. Every 26-bit value is legal.
- BR: `{11'b11010110000, 5'b0, 6'b0, rn, 5'b0}`.
- NOP pad word: 0x8B1F03FF (ADD XZR,XZR,XZR).
- FSM states IDLE, LOAD, FILL, DONE. Reset enters IDLE.
- IDLE: `start` → LOAD. Entering LOAD clears ptr and both error flags.
- LOAD: `in_ready = !start && ptr < N_WORDS`. A handshake (`in_valid && in_ready`) encodes the fields.
  - Legal instruction: register the write, `ptr++`.
  - Illegal instruction: no write, ptr unchanged, set the matching sticky error. The stream continues.
  - After a handshake with `in_last`: if the new ptr is below N_WORDS → FILL, otherwise → DONE. A rejected last word also ends the program.
  - If ptr reaches N_WORDS without `in_last` → DONE.
- FILL: write a NOP to address ptr each cycle and increment the pad pointer. `count` stays frozen. After address N_WORDS−1 → DONE.
- DONE: hold. `start` → LOAD.
- `start` in LOAD or FILL restarts immediately: ptr 0, errors cleared, in-progress FILL aborted. `start` takes priority over a same-cycle handshake, because `in_ready` is 0 while `start` is high.
- Illegal mnemonic and range errors are exclusive. An illegal mnemonic never checks the range.

## Timing
- Reset values: `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `busy` 0, `done` 0, errors 0, `count` 0, `in_ready` 0.
- `in_ready` is combinational from state, ptr and `start`. All other outputs are registered.
- Write latency is 1 cycle. For a handshake at edge t, `imem_we`, `imem_addr` and `imem_wdata` are valid during cycle t+1 and `count` updates at t+1.
- `imem_we` is high for exactly one cycle per written word. Back-to-back handshakes produce one write per cycle.
- FILL issues one write per cycle. `done` rises the cycle after the final pad write is presented.
- `reset_n` low at any edge, including mid-FILL, forces the reset values next cycle. A write that is in flight is dropped.

## Structure
- `legv8_pkg` holds:
  - the mnemonic enum `mnem_t`
  - the 11-bit opcode constants and the CBZ/B opcode constants
  - `NOP_WORD`
  - the immediate range limits
  - the FSM state enum.
- Sub-module `instenc`: purely combinational. It maps (mnem, rd, rn, rm, imm) to (word, illegal, range_err). The top level holds the FSM, pointer, and output registers.

## Test plan
- ADD rd=1, rn=2, rm=3 at ptr 0 → next cycle `imem_we`=1, addr 0, wdata 0x8B030041, `count`=1.
- LDUR rd=9, rn=10, imm=−8 → 0xF85F8149. CBZ rd=5, imm=−2 → 0xB4FFFFC5. B imm=4 → 0x14000004. BR rn=30 → 0xD60003C0. All four are sent back-to-back with 4 consecutive writes.
- STUR imm=256 → no write, ptr unchanged, `err_range`=1. Then mnem 12 → no write, `err_illegal`=1. A following ADD is written at the unchanged address.
- N_WORDS=8, three instructions with the third flagged `in_last` → addresses 3..7 get 0x8B1F03FF on 5 consecutive cycles, `done`=1, `count`=3.
- N_WORDS=8, eight instructions without `in_last` → DONE with no padding, and `in_ready` is 0 from the cycle ptr reaches 8.
- `start` after 2 writes in LOAD, with `in_valid` high the same cycle → no accept, next write goes to addr 0, errors cleared. `reset_n` low mid-FILL → all outputs at reset values and state IDLE.
